// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA definitions for the fetch stage and decoder: field positions,
// fetch FSM encodings and the NOP encoding.
package instr_fetch_unit_pkg;

  localparam int ISA_W    = 16;
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 9;
  localparam int RB_MSB   = 8;
  localparam int RB_LSB   = 6;
  localparam int RC_MSB   = 5;
  localparam int RC_LSB   = 3;
  localparam int IMM5_MSB = 4;
  localparam int IMM5_LSB = 0;

  localparam logic [ISA_W-1:0] NOP_ENC = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [OP_MSB-OP_LSB:0]     op;
    logic [RA_MSB-RA_LSB:0]     ra;
    logic [RB_MSB-RB_LSB:0]     rb;
    logic [RC_MSB-RC_LSB:0]     rc;
    logic [IMM5_MSB-IMM5_LSB:0] imm5;
  } ir_fields_t;

endpackage

// File: rtl/instr_fetch_unit_ir_fields.sv
// Combinational instruction-field slicer; shared between fetch and decode.
// rc and imm5 overlap on ir[4:3] by ISA design.
module ir_fields
  import instr_fetch_unit_pkg::*;
(
  input  logic [ISA_W-1:0] ir,
  output ir_fields_t       fields
);

  always_comb begin
    fields      = '0;
    fields.op   = ir[OP_MSB:OP_LSB];
    fields.ra   = ir[RA_MSB:RA_LSB];
    fields.rb   = ir[RB_MSB:RB_LSB];
    fields.rc   = ir[RC_MSB:RC_LSB];
    fields.imm5 = ir[IMM5_MSB:IMM5_LSB];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, IR and req/ack fetch FSM (IDLE -> REQ -> DONE -> IDLE).
// Optional ack timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0000,
  parameter int                TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              pc_write,
  input  logic [ADDR_W-1:0] pc_next,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        op,
  output logic [2:0]        ra,
  output logic [2:0]        rb,
  output logic [2:0]        rc,
  output logic [4:0]        imm5,
  output logic              fetch_err
);

  fetch_state_e state;
  ir_fields_t   fields;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] timer;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      ir        <= NOP_INSTR;
      mem_req   <= 1'b0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      timer     <= '0;
`endif
    end else begin
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A same-cycle pc_write redirects the fetch, since mem_addr follows pc.
          if (pc_write) pc <= pc_next;
          if (fetch_start) begin
            state   <= ST_REQ;
            mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            timer   <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            ir       <= mem_rdata;
            pc       <= pc + ADDR_W'(1);
            mem_req  <= 1'b0;
            ir_valid <= 1'b1;
            state    <= ST_DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (timer == TMR_W'(TIMEOUT - 1)) begin
            ir        <= NOP_INSTR;
            mem_req   <= 1'b0;
            ir_valid  <= 1'b1;
            fetch_err <= 1'b1;
            state     <= ST_DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
`endif
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef FETCH_TIMEOUT_EN
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
`endif

  assign mem_addr = pc;
  assign busy     = (state != ST_IDLE);

  ir_fields u_fields (
    .ir     (ir[ISA_W-1:0]),
    .fields (fields)
  );

  assign op   = fields.op;
  assign ra   = fields.ra;
  assign rb   = fields.rb;
  assign rc   = fields.rc;
  assign imm5 = fields.imm5;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; define FETCH_TIMEOUT_EN
// to also exercise the ack timeout abort.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_start = 1'b0;
  logic        pc_write = 1'b0;
  logic [15:0] pc_next = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] ir;
  logic        ir_valid;
  logic        busy;
  logic [15:0] pc;
  logic [3:0]  op;
  logic [2:0]  ra, rb, rc;
  logic [4:0]  imm5;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_write(pc_write),
    .pc_next(pc_next), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir(ir), .ir_valid(ir_valid),
    .busy(busy), .pc(pc), .op(op), .ra(ra), .rb(rb), .rc(rc), .imm5(imm5),
    .fetch_err(fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled and inputs driven 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fetch_err", fetch_err, 0);
    tick();
    rst = 1'b0;

    // 1: basic fetch, ack in cycle 1
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 16'h0000);
    chk("t1_ir_valid_early", ir_valid, 0);
    mem_ack = 1'b1; mem_rdata = 16'h3A5F;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    chk("t1_ir_valid", ir_valid, 1);
    chk("t1_ir", ir, 16'h3A5F);
    chk("t1_op", op, 4'h3);
    chk("t1_ra", ra, 3'd5);
    chk("t1_rb", rb, 3'd1);
    chk("t1_rc", rc, 3'd3);
    chk("t1_imm5", imm5, 5'h1F);
    chk("t1_pc", pc, 16'h0001);
    chk("t1_mem_req_low", mem_req, 0);
    chk("t1_fetch_err", fetch_err, 0);
    tick();
    chk("t1_ir_valid_pulse", ir_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_ir_stable", ir, 16'h3A5F);

    // 2: ack delayed 4 cycles
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_mem_req_%0d", i), mem_req, 1);
      chk($sformatf("t2_mem_addr_%0d", i), mem_addr, 16'h0001);
      chk($sformatf("t2_ir_valid_%0d", i), ir_valid, 0);
      tick();
    end
    chk("t2_mem_req_4", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'hC1E2;
    tick();
    mem_ack = 1'b0;
    chk("t2_ir_valid", ir_valid, 1);
    chk("t2_ir", ir, 16'hC1E2);
    chk("t2_op", op, 4'hC);
    chk("t2_pc", pc, 16'h0002);
    tick();

    // 3: pc_write together with fetch_start
    pc_write = 1'b1; pc_next = 16'h0040; fetch_start = 1'b1;
    tick();
    pc_write = 1'b0; fetch_start = 1'b0;
    chk("t3_mem_req", mem_req, 1);
    chk("t3_mem_addr", mem_addr, 16'h0040);
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    chk("t3_pc", pc, 16'h0041);
    chk("t3_ir", ir, 16'h1234);
    tick();

    // 4: wrap from 16'hFFFF; requests while busy are ignored
    pc_write = 1'b1; pc_next = 16'hFFFF;
    tick();
    pc_write = 1'b0;
    chk("t4_pc_load", pc, 16'hFFFF);
    chk("t4_no_fetch", busy, 0);
    fetch_start = 1'b1;
    tick();
    pc_write = 1'b1; pc_next = 16'h1234;
    tick();
    chk("t4_busy_pc", pc, 16'hFFFF);
    chk("t4_busy_addr", mem_addr, 16'hFFFF);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    chk("t4_wrap", pc, 16'h0000);
    chk("t4_ir_valid", ir_valid, 1);
    tick();
    fetch_start = 1'b0; pc_write = 1'b0;
    chk("t4_done_ignored_pc", pc, 16'h0000);
    chk("t4_done_ignored_busy", busy, 0);
    chk("t4_ir", ir, 16'hBEEF);

    // 5: reset mid-REQ, late ack ignored
    pc_write = 1'b1; pc_next = 16'h0077; fetch_start = 1'b1;
    tick();
    pc_write = 1'b0; fetch_start = 1'b0;
    tick();
    chk("t5_pre_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_req", mem_req, 0);
    chk("t5_pc", pc, 16'h0000);
    chk("t5_ir", ir, 16'h0000);
    tick();
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hFACE;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("t5_late_ir_valid", ir_valid, 0);
    chk("t5_late_ir", ir, 16'h0000);
    chk("t5_late_pc", pc, 16'h0000);
    chk("t5_late_busy", busy, 0);

`ifdef FETCH_TIMEOUT_EN
    // 6: timeout abort after 15 REQ cycles
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("t6_pre_ir", ir, 16'h5A5A);
    chk("t6_pre_pc", pc, 16'h0001);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t6_req_%0d", i), mem_req, 1);
      chk($sformatf("t6_err_%0d", i), fetch_err, 0);
      tick();
    end
    chk("t6_req_drop", mem_req, 0);
    chk("t6_fetch_err", fetch_err, 1);
    chk("t6_ir_valid", ir_valid, 1);
    chk("t6_ir_nop", ir, 16'h0000);
    chk("t6_pc", pc, 16'h0001);
    tick();
    chk("t6_err_pulse", fetch_err, 0);
    chk("t6_idle", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
